daa_multiplier_pipe: RTL and testbench

- Parametrised, pipelined successor to the 8x8 registered multiplier.
- Computes an N x N product with a Dadda-style partial-product reduction, split across a configurable number of pipeline stages.
- Supports per-operation signed or unsigned mode and valid/ready handshakes with full backpressure.
- Sits between operand producers and accumulator/datapath consumers, and sustains one multiply per cycle.

---
 rtl/daa_multiplier_pipe.sv | 179 +++++++++++++++++
 tb/tb_daa_multiplier_pipe.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/daa_multiplier_pipe.sv
`default_nettype none
// ============================================================================
// Module   : daa_multiplier_pipe
// Brief    : Pipelined WIDTH x WIDTH signed/unsigned multiplier. Partial
//            products are compressed by a word-level 3:2 carry-save tree.
//            A valid/ready handshake with full backpressure and bubble
//            compression moves each product through STAGES register stages.
// Revision : 1.0 - initial release
// ============================================================================
module daa_multiplier_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            A,
  input  logic [WIDTH-1:0]            B,
  input  logic                        is_signed,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*WIDTH-1:0]          result,
  output logic [$clog2(STAGES+1)-1:0] in_flight
);

  localparam int PW     = 2 * WIDTH;
  // WIDTH positive rows, one inverted sign row and its +1 correction row
  localparam int NROWS  = WIDTH + 2;
  localparam int RDEPTH = 3 * NROWS;
  localparam int RIW    = $clog2(RDEPTH);
  localparam int CW     = $clog2(STAGES + 1);

  // Multiplier operand is treated as a (WIDTH+1)-bit two's-complement value:
  // its top bit carries weight -2^WIDTH, so that row is added as ~(a<<W)+1.
  // All arithmetic is modulo 2^PW, which is exact for both modes.
  function automatic logic [2*PW-1:0] csa_tree(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             sgn);
    logic [PW-1:0] rows [RDEPTH];
    logic [PW-1:0] ax;
    logic [PW-1:0] x;
    logic [PW-1:0] y;
    logic [PW-1:0] z;
    logic          neg;
    ax  = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    neg = sgn & b[WIDTH-1];
    for (int i = 0; i < RDEPTH; i++) rows[i] = '0;
    for (int j = 0; j < WIDTH; j++) rows[RIW'(j)] = b[j] ? (ax << j) : '0;
    rows[WIDTH]   = neg ? ((~ax) << WIDTH) : '0;
    rows[WIDTH+1] = neg ? (PW'(1) << WIDTH) : '0;
    // Rows are consumed three at a time from the head and the sum/carry
    // pair is appended at the tail, giving a log-depth compressor tree.
    for (int s = 0; s < NROWS - 2; s++) begin
      x = rows[RIW'(3*s)];
      y = rows[RIW'(3*s + 1)];
      z = rows[RIW'(3*s + 2)];
      rows[RIW'(NROWS + 2*s)]     = x ^ y ^ z;
      rows[RIW'(NROWS + 2*s + 1)] = ((x & y) | (x & z) | (y & z)) << 1;
    end
    return {rows[RIW'(3*(NROWS-2))], rows[RIW'(3*(NROWS-2) + 1)]};
  endfunction

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] adv;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              accept;
  logic              drain;
  logic [2*PW-1:0]   tree_w;
  logic [PW-1:0]     tsum_w;
  logic [PW-1:0]     tcar_w;

  assign tree_w    = csa_tree(A, B, is_signed);
  assign tsum_w    = tree_w[2*PW-1:PW];
  assign tcar_w    = tree_w[PW-1:0];
  assign in_ready  = !reset && adv[0];
  assign accept    = in_valid && in_ready;
  assign drain     = vld_q[STAGES-1] && out_ready;
  assign out_valid = vld_q[STAGES-1];
  assign in_flight = cnt_q;

  // Stage k may load when the output drains or any stage from k down is empty
  always_comb begin
    logic [STAGES-1:0] m;
    adv = '0;
    m   = '0;
    for (int k = 0; k < STAGES; k++) begin
      m      = {STAGES{1'b1}} << k;
      adv[k] = out_ready || ((vld_q & m) != m);
    end
  end

  // Valid bits shift forward where allowed; occupancy tracks accept vs drain
  always_comb begin
    vld_d = vld_q;
    if (adv[0]) vld_d[0] = accept;
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) vld_d[k] = vld_q[k-1];
    end
    cnt_d = cnt_q;
    if (accept && !drain)      cnt_d = cnt_q + 1'b1;
    else if (!accept && drain) cnt_d = cnt_q - 1'b1;
  end

  // Control state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  generate
    if (STAGES == 1) begin : g_single
      logic [PW-1:0] prod_q;
      logic [PW-1:0] prod_d;

      // Single stage: tree and final carry-propagate add in one cycle
      always_comb begin
        prod_d = prod_q;
        if (accept) prod_d = tsum_w + tcar_w;
      end

      // Result register
      always_ff @(posedge clk or posedge reset) begin
        if (reset) prod_q <= '0;
        else       prod_q <= prod_d;
      end

      assign result = prod_q;
    end else begin : g_multi
      logic [PW-1:0] sum_q;
      logic [PW-1:0] sum_d;
      logic [PW-1:0] car_q;
      logic [PW-1:0] car_d;
      logic [PW-1:0] prod_q [1:STAGES-1];
      logic [PW-1:0] prod_d [1:STAGES-1];

      // Stage 0 keeps the carry-save pair, stage 1 resolves it, the rest
      // only carry the product; data loads only with a valid operation so
      // the result holds its last value across bubbles.
      always_comb begin
        sum_d = sum_q;
        car_d = car_q;
        if (accept) begin
          sum_d = tsum_w;
          car_d = tcar_w;
        end
        for (int k = 1; k < STAGES; k++) prod_d[k] = prod_q[k];
        if (adv[1] && vld_q[0]) prod_d[1] = sum_q + car_q;
        for (int k = 2; k < STAGES; k++) begin
          if (adv[k] && vld_q[k-1]) prod_d[k] = prod_q[k-1];
        end
      end

      // Datapath registers
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sum_q <= '0;
          car_q <= '0;
          for (int k = 1; k < STAGES; k++) prod_q[k] <= '0;
        end else begin
          sum_q <= sum_d;
          car_q <= car_d;
          for (int k = 1; k < STAGES; k++) prod_q[k] <= prod_d[k];
        end
      end

      assign result = prod_q[STAGES-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_daa_multiplier_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_daa_multiplier_pipe
// Brief    : Self-checking bench for daa_multiplier_pipe. An 8x8/3-stage and a
//            16x16/5-stage instance share clock and reset; stimulus drives
//            one at a time against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_daa_multiplier_pipe;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          sgn;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          t;
  } entry_t;

  localparam int NT   = 12;
  localparam int NOPS = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  bit          sel;
  logic        d_valid;
  logic        d_oready;
  logic [15:0] d_a;
  logic [15:0] d_b;
  logic        d_sgn;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [15:0] result8;
  logic [1:0]  in_flight8;
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [31:0] result16;
  logic [2:0]  in_flight16;

  assign in_valid8   = !sel && d_valid;
  assign out_ready8  = sel ? 1'b1 : d_oready;
  assign in_valid16  = sel && d_valid;
  assign out_ready16 = sel ? d_oready : 1'b1;

  daa_multiplier_pipe #(.WIDTH(8), .STAGES(3)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(d_a[7:0]), .B(d_b[7:0]), .is_signed(d_sgn), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .in_flight(in_flight8)
  );

  daa_multiplier_pipe #(.WIDTH(16), .STAGES(5)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
    .A(d_a), .B(d_b), .is_signed(d_sgn), .out_valid(out_valid16),
    .out_ready(out_ready16), .result(result16), .in_flight(in_flight16)
  );

  logic        obs_ready, obs_ovalid;
  logic [31:0] obs_result;
  logic [2:0]  obs_flight;
  assign obs_ready  = sel ? in_ready16  : in_ready8;
  assign obs_ovalid = sel ? out_valid16 : out_valid8;
  assign obs_result = sel ? result16    : {16'b0, result8};
  assign obs_flight = sel ? in_flight16 : {1'b0, in_flight8};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          acc_f;
  bit          held_v;
  logic [31:0] held;
  entry_t      q[$];
  logic [31:0] got[$];
  vec_t        tbl [NT];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Exact product from plain integer arithmetic, truncated to 2*w bits
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input bit sgn, input int w);
    longint va, vb, p, msk;
    msk = (longint'(1) << w) - 1;
    va  = longint'(a) & msk;
    vb  = longint'(b) & msk;
    if (sgn && va[w-1]) va = va - (longint'(1) << w);
    if (sgn && vb[w-1]) vb = vb - (longint'(1) << w);
    p = (va * vb) & ((longint'(1) << (2*w)) - 1);
    return p[31:0];
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // One clock cycle: inputs already applied; sample and score at negedge.
  // The oldest pending operation is never blocked, so it must be visible
  // exactly STAGES-1 edges after its accept edge; the pipe is full exactly
  // when the number of pending operations equals STAGES.
  task automatic step();
    int stg;
    stg = sel ? 5 : 3;
    @(negedge clk);
    chk("in_ready", 32'(obs_ready), 32'((q.size() < stg) || d_oready));
    chk("in_flight", 32'(obs_flight), 32'(q.size()));
    chk("out_valid", 32'(obs_ovalid), 32'(q.size() > 0 && cyc >= q[0].t + stg - 1));
    if (held_v && obs_ovalid) chk("held_result", obs_result, held);
    held_v = obs_ovalid && !d_oready;
    held   = obs_result;
    if (obs_ovalid && d_oready) begin
      got.push_back(obs_result);
      if (q.size() > 0) chk("result", obs_result, q.pop_front().exp);
    end
    acc_f = d_valid && obs_ready;
    if (acc_f) q.push_back('{ref_mul(d_a, d_b, d_sgn, sel ? 16 : 8), cyc + 1});
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_op(input logic [15:0] a, input logic [15:0] b, input bit s);
    d_a   = a;
    d_b   = b;
    d_sgn = s;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, sent;
    bit pend;
    logic [15:0] bp_a [5];
    logic [15:0] bp_b [5];

    tbl[0]  = '{8'h0F, 8'h03, 1'b0, 16'h002D};
    tbl[1]  = '{8'hFF, 8'h02, 1'b0, 16'h01FE};
    tbl[2]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[3]  = '{8'h00, 8'hAB, 1'b0, 16'h0000};
    tbl[4]  = '{8'hFF, 8'h02, 1'b1, 16'hFFFE};
    tbl[5]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[6]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    tbl[7]  = '{8'hFF, 8'h02, 1'b0, 16'h01FE};
    tbl[8]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    tbl[9]  = '{8'h80, 8'hFF, 1'b1, 16'h0080};
    tbl[10] = '{8'h01, 8'h80, 1'b1, 16'hFF80};
    tbl[11] = '{8'hAB, 8'hCD, 1'b0, 16'h88EF};

    reset = 1'b1; sel = 1'b0; d_valid = 1'b0; d_oready = 1'b1;
    d_a = '0; d_b = '0; d_sgn = 1'b0; held_v = 1'b0; held = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready8", 32'(in_ready8), 0);
    chk("rst_out_valid8", 32'(out_valid8), 0);
    chk("rst_result8", 32'(result8), 0);
    chk("rst_in_flight8", 32'(in_flight8), 0);
    chk("rst_in_ready16", 32'(in_ready16), 0);
    chk("rst_out_valid16", 32'(out_valid16), 0);
    chk("rst_result16", result16, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready8", 32'(in_ready8), 1);
    chk("post_rst_in_ready16", 32'(in_ready16), 1);

    // Single operation, latency and return of in_flight to zero
    set_op(16'h000F, 16'h0003, 1'b0);
    d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    repeat (5) step();
    chk("single_count", 32'(got.size()), 1);
    if (got.size() > 0) chk("single_result", got[0], 32'h002D);
    chk("single_in_flight", 32'(in_flight8), 0);

    // Back-to-back table stream, mixed modes
    got.delete();
    for (int i = 0; i < NT; i++) begin
      set_op({8'h00, tbl[i].a}, {8'h00, tbl[i].b}, tbl[i].sgn);
      d_valid = 1'b1;
      step();
      chk("tbl_accept", 32'(acc_f), 1);
    end
    d_valid = 1'b0;
    repeat (5) step();
    chk("tbl_count", 32'(got.size()), NT);
    for (int i = 0; i < NT && i < got.size(); i++) chk($sformatf("tbl_result[%0d]", i), got[i], 32'(tbl[i].exp));

    // Backpressure: five operations against a stalled consumer
    got.delete();
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = 16'($urandom_range(1, 255));
      bp_b[i] = 16'($urandom_range(1, 255));
    end
    idx = 0;
    for (int c = 0; c < 40 && (idx < 5 || q.size() > 0); c++) begin
      if (c == 8) begin
        chk("bp_in_flight_full", 32'(in_flight8), 3);
        chk("bp_in_ready_low", 32'(in_ready8), 0);
        chk("bp_accepted", idx, 3);
      end
      d_valid  = (idx < 5);
      if (idx < 5) set_op(bp_a[idx], bp_b[idx], 1'b0);
      d_oready = (c >= 8);
      step();
      if (acc_f) idx++;
    end
    d_valid = 1'b0; d_oready = 1'b1;
    chk("bp_delivered", 32'(got.size()), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("bp_order", got[i], 32'(bp_a[i] * bp_b[i]));

    // Asynchronous reset with two operations in flight
    d_oready = 1'b0;
    set_op(16'h0012, 16'h0034, 1'b0); d_valid = 1'b1; step();
    set_op(16'h0056, 16'h0078, 1'b1); step();
    d_valid = 1'b0;
    step(); step();
    chk("mid_in_flight", 32'(in_flight8), 2);
    chk("mid_result", 32'(result8), 32'h03A8);
    #3 reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid8), 0);
    chk("arst_in_flight", 32'(in_flight8), 0);
    chk("arst_result", 32'(result8), 0);
    chk("arst_in_ready", 32'(in_ready8), 0);
    d_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_no_accept", 32'(in_flight8), 0);
    chk("rst_in_ready_hold", 32'(in_ready8), 0);
    reset = 1'b0; d_valid = 1'b0; d_oready = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready8), 1);
    q.delete(); got.delete(); held_v = 1'b0;
    repeat (6) step();
    chk("no_stale_output", 32'(got.size()), 0);

    // Randomized sweep on the 16x16 / 5-stage instance
    sel = 1'b1; sent = 0; pend = 1'b0;
    for (int c = 0; c < 20000 && (sent < NOPS || q.size() > 0); c++) begin
      if (!pend && sent < NOPS && $urandom_range(0, 9) < 7) begin
        pend = 1'b1;
        set_op(pick(), pick(), 1'($urandom_range(0, 1)));
      end
      d_valid  = pend;
      d_oready = (sent >= NOPS) || ($urandom_range(0, 9) < 6);
      step();
      if (acc_f) begin
        sent++;
        pend = 1'b0;
      end
    end
    d_valid = 1'b0;
    chk("rand_sent", sent, NOPS);
    chk("rand_drained", 32'(q.size()), 0);
    chk("rand_in_flight", 32'(in_flight16), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
